icache_set_assoc: RTL and testbench

Set-associative, blocking instruction cache between the Instruction Unit and the memory controller, with a parametrised number of sets, ways and block size. On a miss it runs its own refill handshake: it requests one block, installs it with round-robin replacement, and returns the requested word. It also supports a whole-cache flush for `fence.i`.

---
 rtl/icache_pkg.sv | 23 ++
 rtl/icache_way.sv | 65 ++++++
 rtl/icache_set_assoc.sv | 227 ++++++++++++++++++++++
 tb/tb_icache_set_assoc.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// ----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the set-associative instruction cache:
//   - refill controller state encoding (IDLE / REQ / WAIT)
//   - tag_width(): tag bits left over after the index and block-offset fields
// ----------------------------------------------------------------------------
package icache_pkg;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_REQ_ENC  = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_REQ  = ST_REQ_ENC,
        ST_WAIT = ST_WAIT_ENC
    } state_e;

    function automatic int tag_width(input int addr_w, input int index_w, input int block_w);
        return addr_w - index_w - block_w;
    endfunction

endpackage

// File: rtl/icache_way.sv
// ----------------------------------------------------------------------------
// icache_way
// One way of the instruction cache: per-set valid bit, tag and data block.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset (clears valids)
//   flush_i             invalidate every set of this way at the next edge
//   rd_idx_i/rd_tag_i   lookup set and tag; hit_o / rd_data_o are combinational
//   wr_idx_i            set being refilled; wr_valid_o reports its valid bit
//   we_i                install wr_tag_i / wr_data_i into set wr_idx_i
// ----------------------------------------------------------------------------
module icache_way
    import icache_pkg::*;
#(
    parameter  int ADDR_WIDTH  = 17,
    parameter  int BLOCK_WIDTH = 4,
    parameter  int INDEX_WIDTH = 6,
    localparam int TAG_WIDTH   = tag_width(ADDR_WIDTH, INDEX_WIDTH, BLOCK_WIDTH),
    localparam int BLOCK_BITS  = 8 << BLOCK_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic [INDEX_WIDTH-1:0] rd_idx_i,
    input  logic [TAG_WIDTH-1:0]   rd_tag_i,
    output logic                   hit_o,
    output logic [BLOCK_BITS-1:0]  rd_data_o,
    input  logic [INDEX_WIDTH-1:0] wr_idx_i,
    output logic                   wr_valid_o,
    input  logic                   we_i,
    input  logic [TAG_WIDTH-1:0]   wr_tag_i,
    input  logic [BLOCK_BITS-1:0]  wr_data_i
);

    localparam int SETS = 1 << INDEX_WIDTH;

    logic [SETS-1:0]       valid_q;
    logic [TAG_WIDTH-1:0]  tag_q  [SETS];
    logic [BLOCK_BITS-1:0] data_q [SETS];

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays are deliberately left out of reset; the valid
    // bits alone qualify their contents, which keeps them mappable to RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign hit_o      = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_data_o  = data_q[rd_idx_i];
    assign wr_valid_o = valid_q[wr_idx_i];

endmodule

// File: rtl/icache_set_assoc.sv
// ----------------------------------------------------------------------------
// icache_set_assoc
// Blocking set-associative instruction cache with its own refill handshake,
// round-robin replacement and whole-cache flush (fence.i).
// Ports:
//   clkIn, resetIn              clock, asynchronous active-high reset
//   flushIn                     invalidate all lines
//   instrInValid/instrAddrIn    fetch request (accepted when instrReady)
//   instrReady                  controller idle, request can be accepted
//   instrOutValid/instrOut      one-cycle pulse with the fetched word
//   memReqValid/memReqAddr      block refill request, held until memReqReady
//   memReqReady                 memory controller accepted the request
//   memDataValid/memDataIn      refill block, byte 0 in bits [7:0]
// ----------------------------------------------------------------------------
module icache_set_assoc
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int BLOCK_WIDTH = 4,
    parameter int INDEX_WIDTH = 6,
    parameter int WAY_WIDTH   = 1
) (
    input  logic                              clkIn,
    input  logic                              resetIn,
    input  logic                              flushIn,
    input  logic                              instrInValid,
    input  logic [ADDR_WIDTH-1:0]             instrAddrIn,
    output logic                              instrReady,
    output logic                              instrOutValid,
    output logic [31:0]                       instrOut,
    output logic                              memReqValid,
    output logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] memReqAddr,
    input  logic                              memReqReady,
    input  logic                              memDataValid,
    input  logic [(8<<BLOCK_WIDTH)-1:0]       memDataIn
);

    localparam int TAG_WIDTH  = tag_width(ADDR_WIDTH, INDEX_WIDTH, BLOCK_WIDTH);
    localparam int WAYS       = 1 << WAY_WIDTH;
    localparam int SETS       = 1 << INDEX_WIDTH;
    localparam int BLOCK_BITS = 8 << BLOCK_WIDTH;
    localparam int WORDS      = 1 << (BLOCK_WIDTH - 2);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_e                              state_q, state_d;
    logic [ADDR_WIDTH-1:0]               addr_q, addr_d;
    logic                                out_valid_q, out_valid_d;
    logic [31:0]                         out_q, out_d;
    logic                                req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-BLOCK_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic                                drop_q, drop_d;
    logic [SETS-1:0][WAY_WIDTH-1:0]      rr_q, rr_d;

    // ------------------------------------------------------------------------
    // Address fields: lookups use the live request address, refills use the
    // address latched at acceptance.
    // ------------------------------------------------------------------------
    logic [INDEX_WIDTH-1:0] rd_idx, wr_idx;
    logic [TAG_WIDTH-1:0]   rd_tag, wr_tag;

    assign rd_idx = instrAddrIn[BLOCK_WIDTH +: INDEX_WIDTH];
    assign rd_tag = instrAddrIn[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign wr_idx = addr_q[BLOCK_WIDTH +: INDEX_WIDTH];
    assign wr_tag = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];

    function automatic logic [31:0] pick_word(input logic [BLOCK_BITS-1:0] blk,
                                              input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] w;
        logic [31:0]           r;
        w = (addr >> 2) & ADDR_WIDTH'(WORDS - 1);
        r = blk[31:0];
        for (int i = 0; i < WORDS; i++) begin
            if (w == ADDR_WIDTH'(i)) r = blk[32*i +: 32];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Ways
    // ------------------------------------------------------------------------
    logic [WAYS-1:0]       way_hit;
    logic [WAYS-1:0]       way_wvld;
    logic [BLOCK_BITS-1:0] way_data [WAYS];
    logic [WAY_WIDTH-1:0]  victim;
    logic                  all_valid;
    logic                  fill_fire;
    logic                  install;

    assign fill_fire = (state_q == ST_WAIT) && memDataValid;
    // A flush on the fill edge wins: the block is still returned, never stored.
    assign install   = fill_fire && !drop_q && !flushIn;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        icache_way #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .BLOCK_WIDTH(BLOCK_WIDTH),
            .INDEX_WIDTH(INDEX_WIDTH)
        ) u_way (
            .clk_i     (clkIn),
            .rst_i     (resetIn),
            .flush_i   (flushIn),
            .rd_idx_i  (rd_idx),
            .rd_tag_i  (rd_tag),
            .hit_o     (way_hit[g]),
            .rd_data_o (way_data[g]),
            .wr_idx_i  (wr_idx),
            .wr_valid_o(way_wvld[g]),
            .we_i      (install && (victim == WAY_WIDTH'(g))),
            .wr_tag_i  (wr_tag),
            .wr_data_i (memDataIn)
        );
    end

    // Hit-way mux; at most one way can match a given tag.
    logic                  hit_any;
    logic [BLOCK_BITS-1:0] hit_blk;

    // NOTE: every signal driven in always_comb gets a default first, so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        hit_any = 1'b0;
        hit_blk = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_hit[w]) begin
                hit_any = 1'b1;
                hit_blk = way_data[w];
            end
        end
    end

    // Victim: lowest invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        logic found;
        found  = 1'b0;
        victim = rr_q[wr_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !way_wvld[w]) begin
                victim = WAY_WIDTH'(w);
                found  = 1'b1;
            end
        end
        all_valid = !found;
    end

    // ------------------------------------------------------------------------
    // Controller next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        out_valid_d = 1'b0;
        out_d       = out_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        drop_d      = drop_q;
        rr_d        = rr_q;

        if (flushIn && (state_q != ST_IDLE)) drop_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (instrInValid) begin
                    addr_d = instrAddrIn;
                    // A same-cycle flush turns the lookup into a miss.
                    if (hit_any && !flushIn) begin
                        out_valid_d = 1'b1;
                        out_d       = pick_word(hit_blk, instrAddrIn);
                    end else begin
                        state_d     = ST_REQ;
                        req_valid_d = 1'b1;
                        req_addr_d  = instrAddrIn[ADDR_WIDTH-1:BLOCK_WIDTH];
                    end
                end
            end
            ST_REQ: begin
                // Data arriving alongside the request handshake is ignored.
                if (memReqReady) begin
                    state_d     = ST_WAIT;
                    req_valid_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (memDataValid) begin
                    out_valid_d = 1'b1;
                    out_d       = pick_word(memDataIn, addr_q);
                    state_d     = ST_IDLE;
                    drop_d      = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pointer only advances when a valid line is actually replaced.
        if (install && all_valid) rr_d[wr_idx] = rr_q[wr_idx] + 1'b1;
    end

    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            drop_q      <= 1'b0;
            rr_q        <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            drop_q      <= drop_d;
            rr_q        <= rr_d;
        end
    end

    assign instrReady    = (state_q == ST_IDLE);
    assign instrOutValid = out_valid_q;
    assign instrOut      = out_q;
    assign memReqValid   = req_valid_q;
    assign memReqAddr    = req_addr_q;

endmodule

// File: tb/tb_icache_set_assoc.sv
// ----------------------------------------------------------------------------
// tb_icache_set_assoc
// Self-checking bench for icache_set_assoc with default parameters
// (17-bit address, 16-byte blocks, 64 sets, 2 ways, 7-bit tag).
// ----------------------------------------------------------------------------
module tb_icache_set_assoc;

    logic         clkIn = 1'b0;
    logic         resetIn = 1'b0;
    logic         flushIn = 1'b0;
    logic         instrInValid = 1'b0;
    logic [16:0]  instrAddrIn = '0;
    logic         instrReady;
    logic         instrOutValid;
    logic [31:0]  instrOut;
    logic         memReqValid;
    logic [12:0]  memReqAddr;
    logic         memReqReady = 1'b0;
    logic         memDataValid = 1'b0;
    logic [127:0] memDataIn = '0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clkIn = ~clkIn;

    icache_set_assoc dut (
        .clkIn        (clkIn),
        .resetIn      (resetIn),
        .flushIn      (flushIn),
        .instrInValid (instrInValid),
        .instrAddrIn  (instrAddrIn),
        .instrReady   (instrReady),
        .instrOutValid(instrOutValid),
        .instrOut     (instrOut),
        .memReqValid  (memReqValid),
        .memReqAddr   (memReqAddr),
        .memReqReady  (memReqReady),
        .memDataValid (memDataValid),
        .memDataIn    (memDataIn)
    );

    // ------------------------------------------------------------------------
    // Backing memory contents: block 0x004 holds 0,1111..,2222..,3333..
    // ------------------------------------------------------------------------
    function automatic logic [31:0] mem_word(input logic [12:0] blk, input int i);
        return (32'h11111111 * 32'(i)) ^ (32'(blk ^ 13'h004) << 12);
    endfunction

    function automatic logic [127:0] mem_block(input logic [12:0] blk);
        logic [127:0] d;
        for (int i = 0; i < 4; i++) d[32*i +: 32] = mem_word(blk, i);
        return d;
    endfunction

    // ------------------------------------------------------------------------
    // Reference model: which blocks are resident, per set and way.
    // ------------------------------------------------------------------------
    bit          m_valid [64][2];
    logic [6:0]  m_tag   [64][2];
    int          m_rr    [64];

    function automatic void model_reset();
        for (int s = 0; s < 64; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
        end
    endfunction

    // Returns 1 when the fetch must miss; updates residency accordingly.
    function automatic logic model_fetch(input logic [16:0] addr, input logic flush);
        int         idx;
        int         victim;
        logic [6:0] tg;
        idx = int'(addr[9:4]);
        tg  = addr[16:10];
        if (flush) begin
            for (int s = 0; s < 64; s++)
                for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
        end
        for (int w = 0; w < 2; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == tg) return 1'b0;
        victim = -1;
        for (int w = 0; w < 2; w++)
            if (victim < 0 && !m_valid[idx][w]) victim = w;
        if (victim < 0) begin
            victim    = m_rr[idx];
            m_rr[idx] = (m_rr[idx] + 1) % 2;
        end
        m_valid[idx][victim] = 1'b1;
        m_tag[idx][victim]   = tg;
        return 1'b1;
    endfunction

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // One complete fetch; on a miss the bench plays the memory controller.
    task automatic do_fetch(input logic [16:0] addr, input logic flush,
                            input int req_dly, input int dat_dly,
                            output logic missed, output logic [31:0] word, output logic ok);
        logic held;
        missed = 1'b0;
        word   = '0;
        ok     = 1'b0;
        held   = 1'b1;
        @(negedge clkIn);
        instrInValid = 1'b1;
        instrAddrIn  = addr;
        flushIn      = flush;
        @(posedge clkIn); #1;
        instrInValid = 1'b0;
        flushIn      = 1'b0;
        if (instrOutValid) begin
            word = instrOut;
            ok   = 1'b1;
        end else if (memReqValid) begin
            missed = 1'b1;
            check("req_addr", memReqAddr, addr[16:4]);
            for (int i = 0; i < req_dly; i++) begin
                @(posedge clkIn); #1;
                if (!(memReqValid && memReqAddr == addr[16:4])) held = 1'b0;
            end
            if (req_dly > 0) check("req_held", held, 1);
            @(negedge clkIn);
            memReqReady = 1'b1;
            @(posedge clkIn); #1;
            memReqReady = 1'b0;
            check("req_drop", memReqValid, 0);
            repeat (dat_dly) @(posedge clkIn);
            @(negedge clkIn);
            memDataValid = 1'b1;
            memDataIn    = mem_block(addr[16:4]);
            @(posedge clkIn); #1;
            memDataValid = 1'b0;
            if (instrOutValid) begin
                word = instrOut;
                ok   = 1'b1;
            end
        end
    endtask

    typedef struct {
        logic [16:0] addr;
        logic        flush;
        logic        exp_miss;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic        missed, ok, fl, exp_miss;
        logic [31:0] word;
        logic [16:0] addr;

        // Directed sequence; all blocks map to set 4 (tags 0, 1, 2).
        vecs[0] = '{17'h0044, 1'b0, 1'b1, 32'h11111111};
        vecs[1] = '{17'h0048, 1'b0, 1'b0, 32'h22222222};
        vecs[2] = '{17'h0040, 1'b0, 1'b0, mem_word(13'h004, 0)};
        vecs[3] = '{17'h0440, 1'b0, 1'b1, mem_word(13'h044, 0)};
        vecs[4] = '{17'h0840, 1'b0, 1'b1, mem_word(13'h084, 0)};  // evicts way0 (0x040)
        vecs[5] = '{17'h004C, 1'b0, 1'b1, mem_word(13'h004, 3)};  // evicts way1 (0x440)
        vecs[6] = '{17'h0844, 1'b0, 1'b0, mem_word(13'h084, 1)};
        vecs[7] = '{17'h0440, 1'b0, 1'b1, mem_word(13'h044, 0)};
        vecs[8] = '{17'h0044, 1'b1, 1'b1, mem_word(13'h004, 1)};  // flush + fetch
        vecs[9] = '{17'h0048, 1'b0, 1'b0, mem_word(13'h004, 2)};

        // Reset state
        #1 resetIn = 1'b1;
        #1;
        check("rst_ready", instrReady, 1);
        check("rst_outvalid", instrOutValid, 0);
        check("rst_out", instrOut, 0);
        check("rst_reqvalid", memReqValid, 0);
        check("rst_reqaddr", memReqAddr, 0);
        @(negedge clkIn);
        resetIn = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_fetch(vecs[i].addr, vecs[i].flush, 2, 1, missed, word, ok);
            check($sformatf("vec%0d_resp", i), ok, 1);
            check($sformatf("vec%0d_miss", i), missed, vecs[i].exp_miss);
            check($sformatf("vec%0d_word", i), word, vecs[i].exp_word);
        end

        // Four back-to-back hits on block 0x004
        @(negedge clkIn);
        instrInValid = 1'b1;
        instrAddrIn  = 17'h0040;
        for (int i = 0; i < 4; i++) begin
            @(posedge clkIn); #1;
            check($sformatf("b2b%0d_valid", i), instrOutValid, 1);
            check($sformatf("b2b%0d_word", i), instrOut, mem_word(13'h004, i));
            check($sformatf("b2b%0d_ready", i), instrReady, 1);
            if (i < 3) instrAddrIn = 17'h0040 + 17'(4 * (i + 1));
            else       instrInValid = 1'b0;
        end
        @(posedge clkIn); #1;
        check("b2b_pulse_end", instrOutValid, 0);

        // Flush during WAIT: data returned, not installed
        @(negedge clkIn);
        instrInValid = 1'b1;
        instrAddrIn  = 17'h1234;
        @(posedge clkIn); #1;
        instrInValid = 1'b0;
        check("fw_req", memReqValid, 1);
        @(negedge clkIn); memReqReady = 1'b1;
        @(posedge clkIn); #1; memReqReady = 1'b0;
        check("fw_wait_ready", instrReady, 0);
        @(negedge clkIn); flushIn = 1'b1;
        @(posedge clkIn); #1; flushIn = 1'b0;
        @(negedge clkIn);
        memDataValid = 1'b1;
        memDataIn    = mem_block(13'h123);
        @(posedge clkIn); #1;
        memDataValid = 1'b0;
        check("fw_valid", instrOutValid, 1);
        check("fw_word", instrOut, mem_word(13'h123, 1));
        do_fetch(17'h1234, 1'b0, 0, 0, missed, word, ok);
        check("fw_refetch_miss", missed, 1);
        check("fw_refetch_word", word, mem_word(13'h123, 1));

        // Reset between edges while in REQ
        @(negedge clkIn);
        instrInValid = 1'b1;
        instrAddrIn  = 17'h0ab0;
        @(posedge clkIn); #1;
        instrInValid = 1'b0;
        check("rq_req", memReqValid, 1);
        #2 resetIn = 1'b1;
        #1;
        check("rq_reqvalid", memReqValid, 0);
        check("rq_reqaddr", memReqAddr, 0);
        @(negedge clkIn); resetIn = 1'b0;

        // Reset between edges while in WAIT, then a stray data beat
        @(negedge clkIn);
        instrInValid = 1'b1;
        instrAddrIn  = 17'h2000;
        @(posedge clkIn); #1;
        instrInValid = 1'b0;
        check("rw_req", memReqValid, 1);
        @(negedge clkIn); memReqReady = 1'b1;
        @(posedge clkIn); #1; memReqReady = 1'b0;
        check("rw_in_wait", instrReady, 0);
        #2 resetIn = 1'b1;
        #1;
        check("rw_reqvalid", memReqValid, 0);
        check("rw_outvalid", instrOutValid, 0);
        check("rw_ready", instrReady, 1);
        @(negedge clkIn); resetIn = 1'b0;
        @(negedge clkIn);
        memDataValid = 1'b1;
        memDataIn    = mem_block(13'h200);
        @(posedge clkIn); #1;
        memDataValid = 1'b0;
        check("rw_stray_outvalid", instrOutValid, 0);
        check("rw_stray_ready", instrReady, 1);
        check("rw_stray_reqvalid", memReqValid, 0);

        // Randomized fetches over 4 sets x 4 tags against the model
        model_reset();
        for (int n = 0; n < 150; n++) begin
            addr = {7'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            fl       = ($urandom_range(0, 15) == 0);
            exp_miss = model_fetch(addr, fl);
            do_fetch(addr, fl, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                     missed, word, ok);
            check($sformatf("rnd%0d_resp", n), ok, 1);
            check($sformatf("rnd%0d_miss", n), missed, exp_miss);
            check($sformatf("rnd%0d_word", n), word, mem_word(addr[16:4], int'(addr[3:2])));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
